// File: rtl/f2i32_pipe.sv
// f2i32_pipe: two-stage IEEE-754 single-precision to 32-bit integer converter with valid/ready flow.
// Define F2I32_FLAGS_EN to compute and register the overflow/inexact flags; otherwise both read 0.
module f2i32_pipe #(
  parameter int FPWID = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [2:0]       rm,
  input  logic [FPWID-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FPWID-1:0] o,
  output logic             overflow,
  output logic             inexact
);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RUP = 3'd2,
    RM_RDN = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  // Flow control
  logic s1_v_q, s2_v_q;
  logic s1_load, s2_load;

  assign s2_load   = ce & (~s2_v_q | out_ready);
  assign s1_load   = ce & (~s1_v_q | s2_load);
  assign in_ready  = rst_n & s1_load;
  assign out_valid = s2_v_q;

  // S1 decode / align
  logic [7:0]  exp_w;
  logic [23:0] man_w;
  logic [63:0] fixed_w;
  logic [31:0] s1_int_d;
  logic        s1_g_d, s1_st_d, s1_nan_d, s1_big_d;
  rmode_e      s1_rm_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    exp_w    = a[30:23];
    man_w    = {(exp_w != 8'd0), a[22:0]};
    fixed_w  = 64'd0;
    s1_int_d = 32'd0;
    s1_g_d   = 1'b0;
    s1_st_d  = 1'b0;
    s1_nan_d = (exp_w == 8'hFF) && (a[22:0] != 23'd0);
    s1_big_d = (exp_w >= 8'd159);
    if (exp_w < 8'd126) begin
      s1_st_d = |a[30:0];
    end else if (!s1_big_d) begin
      // 32 integer bits over 32 fraction bits; value = m * 2^(e-150), so shift is e-118 (8..40).
      fixed_w  = {40'd0, man_w} << (exp_w - 8'd118);
      s1_int_d = fixed_w[63:32];
      s1_g_d   = fixed_w[31];
      s1_st_d  = |fixed_w[30:0];
    end
    case (rm)
      3'd1:    s1_rm_d = RM_RTZ;
      3'd2:    s1_rm_d = RM_RUP;
      3'd3:    s1_rm_d = RM_RDN;
      3'd4:    s1_rm_d = RM_RMM;
      default: s1_rm_d = RM_RNE;
    endcase
  end

  logic [31:0] s1_int_q;
  logic        s1_g_q, s1_st_q, s1_s_q, s1_op_q, s1_nan_q, s1_big_q;
  rmode_e      s1_rm_q;

  // NOTE: payload registers carry no reset; the stage valid bit qualifies them, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_int_q <= s1_int_d;
      s1_g_q   <= s1_g_d;
      s1_st_q  <= s1_st_d;
      s1_s_q   <= a[31];
      s1_op_q  <= op;
      s1_rm_q  <= s1_rm_d;
      s1_nan_q <= s1_nan_d;
      s1_big_q <= s1_big_d;
    end
  end

  // S2 round / range check / negate / saturate
  logic        inc_w, mag_ovf, ovf_d;
  logic [32:0] sum_w;
  logic [31:0] o_d, o_q;

  always_comb begin
    inc_w = 1'b0;
    case (s1_rm_q)
      RM_RNE:  inc_w = s1_g_q & (s1_st_q | s1_int_q[0]);
      RM_RTZ:  inc_w = 1'b0;
      RM_RUP:  inc_w = (s1_g_q | s1_st_q) & ~s1_s_q;
      RM_RDN:  inc_w = (s1_g_q | s1_st_q) & s1_s_q;
      RM_RMM:  inc_w = s1_g_q;
      default: inc_w = 1'b0;
    endcase
    sum_w = {1'b0, s1_int_q} + {32'd0, inc_w};
    if (s1_op_q)
      mag_ovf = s1_s_q ? (sum_w > 33'h0_8000_0000) : (sum_w > 33'h0_7FFF_FFFF);
    else
      mag_ovf = sum_w[32] | (s1_s_q & (sum_w != 33'd0));
    ovf_d = s1_nan_q | s1_big_q | mag_ovf;
    if (s1_nan_q)
      o_d = s1_op_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    else if (ovf_d)
      o_d = s1_s_q ? (s1_op_q ? 32'h8000_0000 : 32'h0000_0000)
                   : (s1_op_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF);
    else
      o_d = (s1_s_q & s1_op_q) ? -sum_w[31:0] : sum_w[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      o_q    <= 32'd0;
    end else begin
      if (s1_load) s1_v_q <= in_valid;
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) o_q <= o_d;
      end
    end
  end

  assign o = o_q;

`ifdef F2I32_FLAGS_EN
  logic ovf_q, inx_q, inx_d;

  assign inx_d = (s1_g_q | s1_st_q) & ~ovf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (s2_load && s1_v_q) begin
      ovf_q <= ovf_d;
      inx_q <= inx_d;
    end
  end

  assign overflow = ovf_q;
  assign inexact  = inx_q;
`else
  assign overflow = 1'b0;
  assign inexact  = 1'b0;
`endif

endmodule
